// File: rtl/mem_sram_controller_pkg.sv
// ----------------------------------------------------------------------------
// mem_sram_controller_pkg
//   Shared definitions for the MEM-stage SRAM access controller: the access
//   state encoding, the default byte address of SRAM word 0, the width of the
//   wait-state counter and the byte-address to word-index helper.
// ----------------------------------------------------------------------------
package mem_sram_controller_pkg;

    // One access walks IDLE -> LO -> HI -> DONE -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          WAIT_CNT_W        = 4;

    // Word index relative to the SRAM base.
    // The subtraction wraps modulo 2^32, so addresses below the base are
    // not rejected; they map somewhere in the SRAM.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_sram_controller_if.sv
// ----------------------------------------------------------------------------
// mem_sram_controller_if
//   Pipeline-side bus between the EX/MEM register and the MEM-stage SRAM
//   controller.
//   Signals:
//     alu_res    byte address of the access
//     value_rm   store data
//     mem_w_en   store request, held until ready
//     mem_r_en   load request, held until ready
//     ready      0 freezes the pipeline while an access is in flight
//     read_data  load result to the MEM/WB register
//   Modports: master = pipeline side, slave = controller.
// ----------------------------------------------------------------------------
interface mem_sram_controller_if;

    logic [31:0] alu_res;
    logic [31:0] value_rm;
    logic        mem_w_en;
    logic        mem_r_en;
    logic        ready;
    logic [31:0] read_data;

    modport master (
        output alu_res,
        output value_rm,
        output mem_w_en,
        output mem_r_en,
        input  ready,
        input  read_data
    );

    modport slave (
        input  alu_res,
        input  value_rm,
        input  mem_w_en,
        input  mem_r_en,
        output ready,
        output read_data
    );

endinterface

// File: rtl/mem_sram_controller.sv
// ----------------------------------------------------------------------------
// mem_sram_controller
//   MEM-stage controller that serves 32-bit loads and stores from an external
//   16-bit asynchronous SRAM. Each access is split into a low-half and a
//   high-half SRAM cycle. Each half cycle lasts WAIT_CYCLES+1 clocks. The
//   pipeline is frozen (ready=0) until the access completes.
//   Parameters:
//     BASE_ADDR    byte address mapped to SRAM word 0
//     SRAM_ADDR_W  SRAM half-word address width (max 31)
//     WAIT_CYCLES  extra clocks each half access is held (0..15)
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        pipeline-side request/response bus (slave modport)
//     sram_addr  SRAM half-word address
//     sram_dq    bidirectional SRAM data bus
//     sram_we_n  SRAM write enable, active-low
//     sram_oe_n  SRAM output enable, active-low
// ----------------------------------------------------------------------------
module mem_sram_controller
    import mem_sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_sram_controller_if.slave   bus,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]            sram_dq,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic                    is_store;
    logic [31:0]             word_q;
    logic [15:0]             wdata_hi_q;
    logic [31:0]             read_data_q;
    logic [15:0]             dq_out;
    logic                    dq_en;

    logic                    req;
    logic [31:0]             word_in;
    logic [SRAM_ADDR_W-1:0]  lo_addr_in;
    logic [SRAM_ADDR_W-1:0]  hi_addr;

    assign req     = bus.mem_w_en | bus.mem_r_en;
    assign word_in = word_index(bus.alu_res, BASE_ADDR);

    // The low-half address is taken straight from the request because the
    // SRAM outputs are registered and must be valid from the first LO cycle.
    // The high half uses the latched word, so a request dropped mid-access
    // still completes with the original address.
    assign lo_addr_in = SRAM_ADDR_W'({word_in, 1'b0});
    assign hi_addr    = SRAM_ADDR_W'({word_q, 1'b1});

    assign bus.ready     = ~req | (state == ST_DONE);
    assign bus.read_data = read_data_q;
    assign sram_dq       = dq_en ? dq_out : 16'hzzzz;

    // Access sequencer.
    // The SRAM-side outputs are registered. Each transition loads the values
    // the next state needs. An asynchronous reset therefore releases
    // we_n and dq at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            is_store    <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            read_data_q <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            dq_out      <= '0;
            dq_en       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        word_q     <= word_in;
                        wdata_hi_q <= bus.value_rm[31:16];
                        // A simultaneous load and store request is treated as a store.
                        is_store   <= bus.mem_w_en;
                        cnt        <= '0;
                        sram_addr  <= lo_addr_in;
                        dq_out     <= bus.value_rm[15:0];
                        if (bus.mem_w_en) begin
                            sram_we_n <= 1'b0;
                            dq_en     <= 1'b1;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                        state <= ST_LO;
                    end
                end

                ST_LO: begin
                    if (cnt == WAIT_LAST) begin
                        if (!is_store) begin
                            read_data_q[15:0] <= sram_dq;
                        end
                        cnt       <= '0;
                        sram_addr <= hi_addr;
                        dq_out    <= wdata_hi_q;
                        state     <= ST_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_HI: begin
                    if (cnt == WAIT_LAST) begin
                        if (!is_store) begin
                            read_data_q[31:16] <= sram_dq;
                        end
                        cnt       <= '0;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        dq_en     <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_mem_sram_controller
//   Bench for mem_sram_controller. It has two instances, with WAIT_CYCLES=1
//   and WAIT_CYCLES=3. Each instance has its own behavioural asynchronous
//   SRAM on a pulled-up data bus, so a released bus reads as 16'hFFFF.
// ----------------------------------------------------------------------------
module tb_mem_sram_controller;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo;
        logic [31:0] rd;
        int          gap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic [17:0] addr1, addr3;
    logic        we1, oe1, we3, oe3;
    tri1  [15:0] dq1, dq3;

    logic [15:0] mem1 [1024];
    logic [15:0] mem3 [1024];

    int          vec_count = 0;
    int          err_count = 0;
    logic [31:0] last_rd [2];
    vec_t        sb [$];
    vec_t        vecs [10];

    always #5 clk = ~clk;

    mem_sram_controller_if bus1 ();
    mem_sram_controller_if bus3 ();

    mem_sram_controller #(
        .BASE_ADDR   (32'd1024),
        .SRAM_ADDR_W (18),
        .WAIT_CYCLES (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .sram_addr (addr1),
        .sram_dq   (dq1),
        .sram_we_n (we1),
        .sram_oe_n (oe1)
    );

    mem_sram_controller #(
        .BASE_ADDR   (32'd1024),
        .SRAM_ADDR_W (18),
        .WAIT_CYCLES (3)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus3),
        .sram_addr (addr3),
        .sram_dq   (dq3),
        .sram_we_n (we3),
        .sram_oe_n (oe3)
    );

    // Behavioural SRAMs: a write happens on each clock edge where we_n is
    // low. A read drives the bus whenever oe_n is low. mem_init fills the
    // memory with a known pattern.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem1[i] <= 16'hA000 ^ 16'(i);
                mem3[i] <= 16'hA000 ^ 16'(i);
            end
        end else begin
            if (!we1) mem1[addr1[9:0]] <= dq1;
            if (!we3) mem3[addr3[9:0]] <= dq3;
        end
    end

    assign dq1 = oe1 ? 16'hzzzz : mem1[addr1[9:0]];
    assign dq3 = oe3 ? 16'hzzzz : mem3[addr3[9:0]];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_bus(input bit sel, input logic w, input logic r,
                             input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus3.mem_w_en = w; bus3.mem_r_en = r; bus3.alu_res = a; bus3.value_rm = d;
        end else begin
            bus1.mem_w_en = w; bus1.mem_r_en = r; bus1.alu_res = a; bus1.value_rm = d;
        end
    endtask

    task automatic sample(input bit sel, output logic rdy, output logic [17:0] a,
                          output logic we, output logic oe, output logic [15:0] dq,
                          output logic [31:0] rd);
        if (sel) begin
            rdy = bus3.ready; a = addr3; we = we3; oe = oe3; dq = dq3; rd = bus3.read_data;
        end else begin
            rdy = bus1.ready; a = addr1; we = we1; oe = oe1; dq = dq1; rd = bus1.read_data;
        end
    endtask

    // Idle cycles: the bus is quiet and read_data keeps its last value.
    task automatic idle_cycles(input bit sel, input int n);
        logic rdy, we, oe;
        logic [17:0] a;
        logic [15:0] dq;
        logic [31:0] rd;
        drive_bus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample(sel, rdy, a, we, oe, dq, rd);
            check_output("idle_ctl", {rdy, we, oe, dq}, {1'b1, 1'b1, 1'b1, 16'hFFFF});
            check_output("idle_read_data", rd, last_rd[sel]);
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_stimulus(input bit sel, input vec_t v);
        idle_cycles(sel, v.gap);
        drive_bus(sel, v.w, v.r, v.addr, v.wdata);
        sb.push_back(v);
    endtask

    // Follows one access cycle by cycle against the expected SRAM waveform.
    // It pops the expected result when ready rises.
    task automatic run_access(input bit sel);
        int          wc;
        int          n;
        bit          done;
        bit          store;
        bit          is_hi;
        vec_t        v;
        logic        rdy, we, oe;
        logic [17:0] a, exp_addr;
        logic [15:0] dq, exp_dq;
        logic [31:0] rd;
        logic [18:0] exp_ctl;
        wc    = sel ? 3 : 1;
        n     = 0;
        done  = 0;
        v     = sb.pop_front();
        store = v.w;
        while (!done && n < 2 * wc + 10) begin
            @(negedge clk);
            n++;
            sample(sel, rdy, a, we, oe, dq, rd);
            if (n >= 2 && n <= 2 * wc + 3) begin
                is_hi    = (n > wc + 2);
                exp_addr = is_hi ? (v.lo | 18'd1) : v.lo;
                if (store) exp_dq = is_hi ? v.wdata[31:16] : v.wdata[15:0];
                else       exp_dq = is_hi ? v.rd[31:16]    : v.rd[15:0];
                exp_ctl = {1'b0, ~store, store, exp_dq};
                check_output($sformatf("sram_addr_c%0d", n), 64'(a), 64'(exp_addr));
            end else begin
                exp_ctl = {(n >= 2 * wc + 4), 1'b1, 1'b1, 16'hFFFF};
            end
            check_output($sformatf("ctl_c%0d", n), {rdy, we, oe, dq}, 64'(exp_ctl));
            if (rdy) begin
                check_output("read_data", rd, v.rd);
                last_rd[sel] = v.rd;
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            vec_count++;
            err_count++;
            $display("[TB] FAIL timeout: ready never rose within %0d cycles", n);
        end
    endtask

    initial begin
        logic        rdy, we, oe;
        logic [17:0] a;
        logic [15:0] dq;
        logic [31:0] rd;
        vec_t        v;

        //             w     r     alu_res        value_rm       lo          expected read_data  gap
        vecs[0] = '{1'b1, 1'b0, 32'd1028,      32'hDEADBEEF, 18'd2,      32'h00000000, 2};
        vecs[1] = '{1'b0, 1'b1, 32'd1028,      32'h0,        18'd2,      32'hDEADBEEF, 1};
        vecs[2] = '{1'b1, 1'b0, 32'd1040,      32'hCAFEF00D, 18'd8,      32'hDEADBEEF, 0};
        vecs[3] = '{1'b0, 1'b1, 32'd1024,      32'h0,        18'd0,      32'hA001A000, 0};
        vecs[4] = '{1'b0, 1'b1, 32'd1040,      32'h0,        18'd8,      32'hCAFEF00D, 0};
        vecs[5] = '{1'b1, 1'b1, 32'd1032,      32'h12345678, 18'd4,      32'hCAFEF00D, 2};
        vecs[6] = '{1'b0, 1'b1, 32'd525320,    32'h0,        18'd4,      32'h12345678, 1};
        vecs[7] = '{1'b1, 1'b0, 32'd0,         32'h0BADC0DE, 18'd261632, 32'h12345678, 1};
        vecs[8] = '{1'b0, 1'b1, 32'd0,         32'h0,        18'd261632, 32'h0BADC0DE, 0};
        vecs[9] = '{1'b0, 1'b1, 32'd1030,      32'h0,        18'd2,      32'hDEADBEEF, 3};

        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        rst        = 1'b1;
        mem_init   = 1'b1;
        drive_bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_bus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample(1'b0, rdy, a, we, oe, dq, rd);
        check_output("reset_state", {rdy, a, we, oe, dq, rd},
                     {1'b1, 18'd0, 1'b1, 1'b1, 16'hFFFF, 32'd0});
        @(posedge clk); #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        $display("[TB] idle bus with no requests");
        idle_cycles(1'b0, 10);

        $display("[TB] table vectors, WAIT_CYCLES=1");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, vecs[i]);
            run_access(1'b0);
        end

        $display("[TB] reset during the high half of a store");
        idle_cycles(1'b0, 1);
        drive_bus(1'b0, 1'b1, 1'b0, 32'd1040, 32'h55556666);
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_output("hi_store_before_rst", {we1, addr1}, {1'b0, 18'd9});
        #2 rst = 1'b1;
        #1;
        check_output("rst_releases_sram", {we1, oe1, dq1, addr1},
                     {1'b1, 1'b1, 16'hFFFF, 18'd0});
        check_output("rst_ready_with_req", 64'(bus1.ready), 64'(1'b0));
        check_output("rst_read_data", bus1.read_data, 32'd0);
        drive_bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_output("rst_ready_no_req", 64'(bus1.ready), 64'(1'b1));
        @(posedge clk); #1;
        rst        = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        // Only the low half of the interrupted store reached the SRAM.
        v = '{1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 32'hCAFE6666, 1};
        apply_stimulus(1'b0, v);
        run_access(1'b0);
        idle_cycles(1'b0, 2);

        $display("[TB] WAIT_CYCLES=3 store and load");
        v = '{1'b1, 1'b0, 32'd1028, 32'h11112222, 18'd2, 32'h00000000, 2};
        apply_stimulus(1'b1, v);
        run_access(1'b1);
        v = '{1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'h11112222, 0};
        apply_stimulus(1'b1, v);
        run_access(1'b1);
        idle_cycles(1'b1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
